// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN = 32;

  // address width that stays at least one bit for degenerate register counts
  function automatic int rf_aw(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/reserve bus of the multi-port register file
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) ();

  localparam int AW = rf_aw(NREGS);

  logic                     init_done;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*XLEN-1:0]   wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;

  modport master (
    input  init_done, rd_data, rd_pend,
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
  );

  modport slave (
    output init_done, rd_data, rd_pend,
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write bits with reserve/retire priority and read-side hazard flags
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = rf_aw(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [NUM_RD-1:0]    rd_pend
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;

  // writes retire pending bits, then a reserve is applied last so it wins on the same register
  always_comb begin
    pend_nxt = pend;
    if (active) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w]) pend_nxt[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (rsv_en) pend_nxt[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  // pending bit register
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_pend
    logic [AW-1:0] addr;
    assign addr = rd_addr[p*AW +: AW];

    // a same-cycle write to the read register is bypassed, so it no longer counts as a hazard
    always_comb begin
      rd_pend[p] = active & pend[addr];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) rd_pend[p] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clear sweep, write bypass and pending scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int AW = rf_aw(NREGS);

  rf_state_t     state;
  rf_state_t     state_nxt;
  logic [AW-1:0] clr_idx;
  logic          clearing;
  logic [XLEN-1:0] mem [NREGS];

  // state register and clear-sweep index
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == RF_CLEAR) clr_idx <= clr_idx + AW'(1);
    end
  end

  // leave the sweep once the last register has been zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      RF_CLEAR: if (clr_idx == AW'(NREGS - 1)) state_nxt = RF_RUN;
      RF_RUN:   state_nxt = RF_RUN;
    endcase
  end

  // state-derived outputs
  always_comb begin
    clearing      = (state == RF_CLEAR);
    bus.init_done = (state == RF_RUN);
  end

  // sweep zeros one register per cycle; in run the write ports apply in index order so the highest wins
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && !((ZERO_REG != 0) && (bus.wr_addr[w*AW +: AW] == '0)))
          mem[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    assign addr = bus.rd_addr[p*AW +: AW];

    // array read overridden by the highest matching write port; forced to zero during sweep and for x0
    always_comb begin
      data = mem[addr];
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == addr))
          data = bus.wr_data[w*XLEN +: XLEN];
      end
      if (clearing || ((ZERO_REG != 0) && (addr == '0))) data = '0;
    end

    assign bus.rd_data[p*XLEN +: XLEN] = data;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .active   (~clearing),
    .rd_addr  (bus.rd_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .rd_pend  (bus.rd_pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp against a register-array model
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_mp_if #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) bus ();

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: register contents, pending set, and edges counted since reset
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_pend [NREGS];
  bit              m_ready = 1'b0;
  int              m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_wr(input int w, input bit en, input int a, input logic [31:0] d);
    bus.wr_en[w]                = en;
    bus.wr_addr[w*AW +: AW]     = a[AW-1:0];
    bus.wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_rsv(input bit en, input int a);
    bus.rsv_en   = en;
    bus.rsv_addr = a[AW-1:0];
  endtask

  task automatic drive_idle();
    bus.wr_en  = '0;
    bus.rsv_en = 1'b0;
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREGS - 1));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic drive_rand();
    for (int p = 0; p < NUM_RD; p++) set_rd(p, pick_addr());
    for (int w = 0; w < NUM_WR; w++) set_wr(w, ($urandom_range(0, 1) == 1), pick_addr(), $urandom);
    set_rsv(($urandom_range(0, 2) == 0), pick_addr());
  endtask

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    int a;
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NREGS) begin
        m_ready = 1'b1;
        foreach (m_reg[i]) m_reg[i] = '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        a = int'(bus.wr_addr[w*AW +: AW]);
        if (bus.wr_en[w] && a != 0) begin
          m_reg[a]  = bus.wr_data[w*XLEN +: XLEN];
          m_pend[a] = 1'b0;
        end
      end
      a = int'(bus.rsv_addr);
      if (bus.rsv_en && a != 0) m_pend[a] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int          a;
    logic [31:0] ev;
    bit          hit;
    bit          ep;
    for (int p = 0; p < NUM_RD; p++) begin
      a   = int'(bus.rd_addr[p*AW +: AW]);
      ev  = m_reg[a];
      hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && int'(bus.wr_addr[w*AW +: AW]) == a) begin
          hit = 1'b1;
          ev  = bus.wr_data[w*XLEN +: XLEN];
        end
      end
      ep = m_pend[a] && !hit;
      if (!m_ready || a == 0) begin
        ev = '0;
        ep = 1'b0;
      end
      check($sformatf("rd_data%0d", p), bus.rd_data[p*XLEN +: XLEN], ev);
      check($sformatf("rd_pend%0d", p), {31'b0, bus.rd_pend[p]}, {31'b0, ep});
    end
    check("init_done", {31'b0, bus.init_done}, {31'b0, m_ready});
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    drive_idle();
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // count edges from reset release until init_done is seen, with random traffic that must be ignored
  task automatic sweep_measure(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      sample();
      if (bus.init_done === 1'b1) begin
        advance();
        break;
      end
      advance();
      n++;
    end
  endtask

  int sweep_len;

  initial begin
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;

    // reset and clear sweep length
    do_reset(1);
    sweep_measure(sweep_len);
    check("sweep_len", sweep_len, 32);
    drive_idle();

    // write r5/r6, read back next cycle
    set_wr(0, 1'b1, 5, 32'h5);
    set_wr(1, 1'b1, 6, 32'h4);
    step();
    drive_idle();
    set_rd(0, 5);
    set_rd(1, 6);
    sample();
    check("r5_read", bus.rd_data[0 +: XLEN], 32'h0000_0005);
    check("r6_read", bus.rd_data[XLEN +: XLEN], 32'h0000_0004);
    advance();

    // same-cycle bypass
    set_wr(0, 1'b1, 7, 32'hDEAD_BEEF);
    set_rd(0, 7);
    sample();
    check("bypass_r7", bus.rd_data[0 +: XLEN], 32'hDEAD_BEEF);
    advance();
    drive_idle();

    // hardwired zero register
    set_wr(0, 1'b1, 0, 32'hFFFF_FFFF);
    set_rsv(1'b1, 0);
    set_rd(0, 0);
    sample();
    check("r0_bypass", bus.rd_data[0 +: XLEN], 32'h0);
    advance();
    drive_idle();
    sample();
    check("r0_read", bus.rd_data[0 +: XLEN], 32'h0);
    check("r0_pend", {31'b0, bus.rd_pend[0]}, 32'h0);
    advance();

    // reserve / retire / simultaneous reserve+write on r9
    set_rsv(1'b1, 9);
    set_rd(1, 9);
    step();
    drive_idle();
    sample();
    check("r9_pend_set", {31'b0, bus.rd_pend[1]}, 32'h1);
    advance();
    set_wr(0, 1'b1, 9, 32'h99);
    sample();
    check("r9_pend_bypass", {31'b0, bus.rd_pend[1]}, 32'h0);
    check("r9_data_bypass", bus.rd_data[XLEN +: XLEN], 32'h99);
    advance();
    drive_idle();
    sample();
    check("r9_pend_clear", {31'b0, bus.rd_pend[1]}, 32'h0);
    advance();
    set_rsv(1'b1, 9);
    set_wr(1, 1'b1, 9, 32'h123);
    step();
    drive_idle();
    sample();
    check("r9_rsv_wins", {31'b0, bus.rd_pend[1]}, 32'h1);
    advance();

    // two write ports on one register: higher port wins
    set_wr(0, 1'b1, 3, 32'h11);
    set_wr(1, 1'b1, 3, 32'h22);
    set_rd(0, 3);
    sample();
    check("r3_bypass_prio", bus.rd_data[0 +: XLEN], 32'h22);
    advance();
    drive_idle();
    sample();
    check("r3_array_prio", bus.rd_data[0 +: XLEN], 32'h22);
    advance();

    // reset asserted mid-sweep restarts the sweep
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      drive_rand();
      step();
    end
    do_reset(1);
    sweep_measure(sweep_len);
    check("sweep_restart_len", sweep_len, 32);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      drive_rand();
      step();
    end
    rst = 1'b0;
    drive_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
